timer_apb_ctrl: RTL and testbench
=================================

Name: timer_apb_ctrl

Overview:
- APB slave control FSM for the 8-bit timer register file (TDR, TCR, TSR).
- Decodes and latches the transfer and inserts a programmable number of wait states.
- Generates pready/pslverr, one-hot register select for the read-data encoder, and single-cycle write strobes.
- Sits between the APB bus and the timer core; the encoder consumes select_reg/pready.

Parameters:
WAIT_CYCLES, 0, wait states inserted in ACCESS before pready (legal 0..7)

Ports:
pclk  input  1  APB clock; all state updates on rising edge
preset  input  1  asynchronous, active-high reset
psel  input  1  APB select
penable  input  1  APB enable
pwrite  input  1  1 = write, 0 = read
paddr  input  8  register address: 0x00 TDR, 0x01 TCR, 0x02 TSR
pwdata  input  8  write data
TDR  input  8  current TDR value from timer core
TCR  input  8  current TCR value
TSR  input  8  current TSR value
pready  output  1  transfer complete
pslverr  output  1  error response, valid only while pready=1
prdata  output  8  read data, valid while pready=1 and read
select_reg  output  3  one-hot latched target: 001 TDR, 010 TCR, 100 TSR, 000 invalid
tdr_we  output  1  one-cycle TDR write strobe
tcr_we  output  1  one-cycle TCR write strobe
tsr_clr  output  8  one-cycle write-1-to-clear mask for TSR
wdata  output  8  latched pwdata

Behaviour:
- Reset (preset=1, async):
  - state=IDLE, cnt=0, addr_q=0, pwrite_q=0, wdata=0.
  - All outputs 0: pready, pslverr, prdata, select_reg, strobes, tsr_clr.
- States: IDLE, ACCESS.
- IDLE:
  - psel=1 & penable=0 (SETUP phase) -> latch paddr, pwrite, pwdata; cnt<=WAIT_CYCLES; go to ACCESS.
  - Any other input combination -> stay in IDLE.
  - penable=1 while in IDLE is ignored.
- ACCESS:
  - pready = (cnt==0) & psel & penable (combinational from registered state and bus inputs).
  - cnt!=0 and psel=1 -> cnt decrements by 1 each cycle, regardless of penable.
  - pready=1 -> the transfer completes at that edge; next state IDLE.
  - psel=0 -> abort: go to IDLE; no strobe, no pready.
- Latency: pready is high in the (WAIT_CYCLES+1)th cycle after the SETUP cycle; WAIT_CYCLES=0 gives a zero-wait transfer.
- Back-to-back: SETUP may occur in the cycle immediately after completion (IDLE detects it); no dead cycle is required.
- Address decode (latched addr_q):
  - 0x00 -> select_reg=001; 0x01 -> 010; 0x02 -> 100.
  - Any other address -> 000 and pslverr=pready.
- select_reg holds its value from the ACCESS entry until the next SETUP latch; it is 0 after reset.
- Reads: while pready=1 & pwrite_q=0, prdata = selected register (TDR/TCR/TSR). Invalid address -> 8'h00. At all other times prdata=8'h00 (never X).
- Writes: strobes are asserted only while pready=1 & pwrite_q=1 & the address is valid.
  - TDR: tdr_we=1.
  - TCR: tcr_we=1.
  - TSR: tsr_clr=wdata (write-1-to-clear); tsr_we does not exist.
  - Invalid address: no strobe, pslverr=1, no state change in the core.
- Strobes are exactly one cycle wide per completed transfer.
- Reset mid-ACCESS: immediate return to IDLE, all outputs 0, transfer lost; the bus master must restart.
- paddr/pwdata changes during ACCESS are ignored (latched copies are used).

Test Plan:
1. WAIT_CYCLES=0: SETUP write paddr=0x00, pwdata=0xA5, then ACCESS -> pready=1 and tdr_we=1 in the first ACCESS cycle, wdata=0xA5, select_reg=001, pslverr=0.
2. WAIT_CYCLES=3: read paddr=0x01 with TCR=0x3C -> pready low for 3 ACCESS cycles, high in the 4th, with prdata=0x3C and select_reg=010; prdata=0x00 outside that cycle.
3. Write paddr=0x02, pwdata=0x81 -> tsr_clr=0x81 for exactly one cycle. Read of paddr=0x07 -> pslverr=1, prdata=0x00, select_reg=000, no strobes.
4. Back-to-back: TDR write 0x11 immediately followed by a TSR read (TSR=0x80) with no idle cycle -> two completions on consecutive ACCESS phases, correct strobe and prdata for each.
5. WAIT_CYCLES=2: psel deasserted in the 2nd ACCESS cycle of a TCR write -> FSM returns to IDLE, tcr_we never asserted, pready stays 0. A following normal read completes correctly.
6. Assert preset asynchronously mid-ACCESS (not on a clock edge) -> all outputs 0 immediately. After release, a read of TDR=0x5A completes with prdata=0x5A.

Source files
------------

// File: rtl/timer_apb_ctrl.sv
// APB slave control FSM for the timer register file (TDR/TCR/TSR).
// Latches the transfer in SETUP, inserts WAIT_CYCLES wait states, then completes with pready.
module timer_apb_ctrl #(
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic       pclk,
   input  logic       preset,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   input  logic [7:0] pwdata,
   input  logic [7:0] TDR,
   input  logic [7:0] TCR,
   input  logic [7:0] TSR,
   output logic       pready,
   output logic       pslverr,
   output logic [7:0] prdata,
   output logic [2:0] select_reg,
   output logic       tdr_we,
   output logic       tcr_we,
   output logic [7:0] tsr_clr,
   output logic [7:0] wdata
);

   typedef enum logic {StIdle, StAccess} state_e;

   localparam logic [2:0] WaitInit = 3'(WAIT_CYCLES);

   state_e     state_q;
   logic [2:0] cnt_q;
   logic [7:0] addr_q;
   logic       pwrite_q;
   logic [7:0] wdata_q;
   logic [2:0] sel_q;
   logic       ready_w;
   logic       addr_ok_w;

   function automatic logic [2:0] decode(input logic [7:0] a);
      case (a)
         8'h00:   decode = 3'b001;
         8'h01:   decode = 3'b010;
         8'h02:   decode = 3'b100;
         default: decode = 3'b000;
      endcase
   endfunction

   assign ready_w   = (state_q == StAccess) && (cnt_q == 3'd0) && psel && penable;
   assign addr_ok_w = (addr_q <= 8'h02);

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q  <= StIdle;
         cnt_q    <= 3'd0;
         addr_q   <= 8'h00;
         pwrite_q <= 1'b0;
         wdata_q  <= 8'h00;
         sel_q    <= 3'b000;
      end else begin
         case (state_q)
            StIdle: begin
               if (psel && !penable) begin
                  addr_q   <= paddr;
                  pwrite_q <= pwrite;
                  wdata_q  <= pwdata;
                  cnt_q    <= WaitInit;
                  sel_q    <= decode(paddr);
                  state_q  <= StAccess;
               end
            end
            StAccess: begin
               // Abort on psel drop; the wait counter runs whether or not penable is high
               if (!psel || ready_w) begin
                  state_q <= StIdle;
               end else if (cnt_q != 3'd0) begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      prdata = 8'h00;
      if (ready_w && !pwrite_q) begin
         case (sel_q)
            3'b001:  prdata = TDR;
            3'b010:  prdata = TCR;
            3'b100:  prdata = TSR;
            default: prdata = 8'h00;
         endcase
      end
   end

   assign pready     = ready_w;
   assign pslverr    = ready_w && !addr_ok_w;
   assign select_reg = sel_q;
   assign wdata      = wdata_q;
   assign tdr_we     = ready_w && pwrite_q && sel_q[0];
   assign tcr_we     = ready_w && pwrite_q && sel_q[1];
   assign tsr_clr    = (ready_w && pwrite_q && sel_q[2]) ? wdata_q : 8'h00;

endmodule

// File: tb/tb_timer_apb_ctrl.sv
// Directed bench for timer_apb_ctrl: three instances (0, 3 and 2 wait states) on a shared bus
// with per-instance psel.
module tb_timer_apb_ctrl;

   logic       pclk = 1'b0;
   logic       preset;
   logic       psel_a [3];
   logic       penable, pwrite;
   logic [7:0] paddr, pwdata;
   logic [7:0] tdr_v, tcr_v, tsr_v;

   logic       pready_a  [3];
   logic       pslverr_a [3];
   logic [7:0] prdata_a  [3];
   logic [2:0] sel_a     [3];
   logic       tdr_we_a  [3];
   logic       tcr_we_a  [3];
   logic [7:0] tsr_clr_a [3];
   logic [7:0] wdata_a   [3];

   int w_cfg [3] = '{0, 3, 2};
   int n_chk = 0;
   int n_bad = 0;

   always #5 pclk = ~pclk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      timer_apb_ctrl #(
         .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
      ) u_dut (
         .pclk      (pclk),
         .preset    (preset),
         .psel      (psel_a[g]),
         .penable   (penable),
         .pwrite    (pwrite),
         .paddr     (paddr),
         .pwdata    (pwdata),
         .TDR       (tdr_v),
         .TCR       (tcr_v),
         .TSR       (tsr_v),
         .pready    (pready_a[g]),
         .pslverr   (pslverr_a[g]),
         .prdata    (prdata_a[g]),
         .select_reg(sel_a[g]),
         .tdr_we    (tdr_we_a[g]),
         .tcr_we    (tcr_we_a[g]),
         .tsr_clr   (tsr_clr_a[g]),
         .wdata     (wdata_a[g])
      );
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_quiet(input int d, input string tag);
      chk({tag, "_pready"}, 8'(pready_a[d]), 8'h00);
      chk({tag, "_we"}, 8'({tdr_we_a[d], tcr_we_a[d]}), 8'h00);
      chk({tag, "_clr"}, tsr_clr_a[d], 8'h00);
      chk({tag, "_rdata"}, prdata_a[d], 8'h00);
   endtask

   // Full transfer on instance d; leaves psel high so a SETUP can follow with no gap
   task automatic xfer(input int d, input logic wr, input logic [7:0] addr, input logic [7:0] data,
                       input logic [2:0] esel, input logic eerr, input logic [7:0] erd);
      int  waits = 0;
      bit  done  = 1'b0;
      @(posedge pclk); #1;
      psel_a[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
      @(negedge pclk);
      chk_quiet(d, "setup");
      @(posedge pclk); #1;
      penable = 1'b1; paddr = 8'hff; pwdata = 8'hee;
      for (int k = 0; k < 12 && !done; k++) begin
         @(negedge pclk);
         chk("sel", 8'(sel_a[d]), 8'(esel));
         if (pready_a[d]) begin
            done = 1'b1;
            chk("rdata", prdata_a[d], erd);
            chk("pslverr", 8'(pslverr_a[d]), 8'(eerr));
            chk("tdr_we", 8'(tdr_we_a[d]), 8'(wr & esel[0]));
            chk("tcr_we", 8'(tcr_we_a[d]), 8'(wr & esel[1]));
            chk("tsr_clr", tsr_clr_a[d], (wr && esel[2]) ? data : 8'h00);
            chk("wdata", wdata_a[d], data);
         end else begin
            waits++;
            chk_quiet(d, "wait");
            chk("wait_err", 8'(pslverr_a[d]), 8'h00);
         end
      end
      chk("done", 8'(done), 8'h01);
      chk("waits", 8'(waits), 8'(w_cfg[d]));
   endtask

   task automatic go_idle(input int d);
      @(posedge pclk); #1;
      psel_a[d] = 1'b0; penable = 1'b0;
      @(negedge pclk);
      chk_quiet(d, "idle");
   endtask

   initial begin
      preset = 1'b1;
      for (int i = 0; i < 3; i++) psel_a[i] = 1'b0;
      penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
      tdr_v = 8'h5a; tcr_v = 8'h3c; tsr_v = 8'h80;
      repeat (2) @(negedge pclk);
      for (int i = 0; i < 3; i++) begin
         chk_quiet(i, "rst");
         chk("rst_sel", 8'(sel_a[i]), 8'h00);
         chk("rst_wdata", wdata_a[i], 8'h00);
         chk("rst_err", 8'(pslverr_a[i]), 8'h00);
      end
      preset = 1'b0;

      // Zero-wait TDR write
      xfer(0, 1'b1, 8'h00, 8'ha5, 3'b001, 1'b0, 8'h00);
      go_idle(0);
      // Three-wait TCR read
      xfer(1, 1'b0, 8'h01, 8'h00, 3'b010, 1'b0, 8'h3c);
      go_idle(1);
      // TSR write-1-to-clear, then invalid-address read
      xfer(0, 1'b1, 8'h02, 8'h81, 3'b100, 1'b0, 8'h00);
      go_idle(0);
      xfer(0, 1'b0, 8'h07, 8'h00, 3'b000, 1'b1, 8'h00);
      go_idle(0);
      // Back-to-back TDR write then TSR read
      xfer(0, 1'b1, 8'h00, 8'h11, 3'b001, 1'b0, 8'h00);
      xfer(0, 1'b0, 8'h02, 8'h00, 3'b100, 1'b0, 8'h80);
      go_idle(0);

      // Abort: psel drops in the 2nd ACCESS cycle of a TCR write
      @(posedge pclk); #1;
      psel_a[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'h42;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      chk("abort1_tcr", 8'(tcr_we_a[2]), 8'h00);
      chk("abort1_rdy", 8'(pready_a[2]), 8'h00);
      @(posedge pclk); #1;
      psel_a[2] = 1'b0;
      @(negedge pclk);
      chk("abort2_tcr", 8'(tcr_we_a[2]), 8'h00);
      chk("abort2_rdy", 8'(pready_a[2]), 8'h00);
      @(posedge pclk); #1;
      penable = 1'b0;
      @(negedge pclk);
      chk_quiet(2, "abort3");
      xfer(2, 1'b0, 8'h01, 8'h00, 3'b010, 1'b0, 8'h3c);
      go_idle(2);

      // Asynchronous reset in the middle of a TDR read
      @(posedge pclk); #1;
      psel_a[1] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h77;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      chk("pre_rst_sel", 8'(sel_a[1]), 8'h01);
      chk("pre_rst_wdata", wdata_a[1], 8'h77);
      #3 preset = 1'b1;
      #1;
      chk("arst_sel1", 8'(sel_a[1]), 8'h00);
      chk("arst_wdata1", wdata_a[1], 8'h00);
      chk("arst_sel0", 8'(sel_a[0]), 8'h00);
      chk_quiet(1, "arst");
      psel_a[1] = 1'b0; penable = 1'b0;
      @(negedge pclk); #2;
      preset = 1'b0;
      xfer(1, 1'b0, 8'h00, 8'h00, 3'b001, 1'b0, 8'h5a);
      go_idle(1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
